led_multi_blink: RTL and testbench

LED_MULTI_BLINK -- requirements
Module: led_multi_blink

---
 rtl/led_multi_blink_pkg.sv | 52 +++++
 rtl/led_blink_chan.sv | 92 +++++++++
 rtl/led_multi_blink.sv | 134 +++++++++++++
 tb/tb_led_multi_blink.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_multi_blink_pkg.sv
// Register map, CTRL field layout and channel FSM encoding shared by led_multi_blink
// and led_blink_chan (layout is identical with or without LED_MULTI_BLINK_PWM_EN).
package led_multi_blink_pkg;

    localparam int unsigned CSR_W  = 32;
    localparam int unsigned RATE_W = 4;
    localparam int unsigned DUTY_W = 8;
    localparam int unsigned IDX_W  = 4;

    localparam logic [CSR_W-1:0] STATUS_ADDR = 32'h0000_0040;
    localparam logic [CSR_W-1:0] DONE_ADDR   = 32'h0000_0044;

    localparam int unsigned CTRL_ENABLE_BIT  = 0;
    localparam int unsigned CTRL_RATE_LSB    = 1;
    localparam int unsigned CTRL_ONESHOT_BIT = 5;
    localparam int unsigned CTRL_DUTY_LSB    = 8;

    localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } chan_state_e;

    typedef struct packed {
        logic [DUTY_W-1:0] duty;
        logic              oneshot;
        logic [RATE_W-1:0] rate;
        logic              enable;
    } ctrl_t;

    function automatic ctrl_t ctrl_unpack(input logic [CSR_W-1:0] w);
        ctrl_t c;
        c.enable  = w[CTRL_ENABLE_BIT];
        c.rate    = w[CTRL_RATE_LSB +: RATE_W];
        c.oneshot = w[CTRL_ONESHOT_BIT];
        c.duty    = w[CTRL_DUTY_LSB +: DUTY_W];
        return c;
    endfunction

    function automatic logic [CSR_W-1:0] ctrl_pack(input ctrl_t c);
        logic [CSR_W-1:0] w;
        w                           = '0;
        w[CTRL_ENABLE_BIT]          = c.enable;
        w[CTRL_RATE_LSB +: RATE_W]  = c.rate;
        w[CTRL_ONESHOT_BIT]         = c.oneshot;
        w[CTRL_DUTY_LSB +: DUTY_W]  = c.duty;
        return w;
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: half-period counter plus IDLE/ON/OFF sequencer; done_c pulses on
// the cycle a one-shot ON phase expires.
module led_blink_chan
    import led_multi_blink_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              oneshot_i,
    input  logic [RATE_W-1:0] rate_i,
    input  logic              restart_i,
    output logic              on_o,
    output logic              done_c
);

    localparam int unsigned CNT_W = $clog2(16 * PRESCALE);
    localparam int unsigned HP_W  = CNT_W + 1;

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HP_W-1:0]  hp;
    logic [CNT_W-1:0] hp_m1;
    logic             at_end;

    // Half period (rate+1)*PRESCALE; only HP-1 is needed and it always fits the counter.
    always_comb begin
        hp     = (HP_W'(rate_i) + HP_W'(1)) * HP_W'(PRESCALE);
        hp_m1  = CNT_W'(hp - HP_W'(1));
        at_end = (cnt_q == hp_m1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_c  = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
                ST_ON: begin
                    if (restart_i) begin
                        cnt_d = '0;
                    end else if (at_end) begin
                        cnt_d = '0;
                        if (oneshot_i) begin
                            state_d = ST_IDLE;
                            done_c  = 1'b1;
                        end else begin
                            state_d = ST_OFF;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (restart_i) begin
                        cnt_d = '0;
                    end else if (at_end) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign on_o = (state_q == ST_ON);

endmodule

// File: rtl/led_multi_blink.sv
// CSR-programmable multi-channel LED blinker. Define LED_MULTI_BLINK_PWM_EN to add
// per-channel DUTY gating from a free-running 8-bit PWM counter.
module led_multi_blink
    import led_multi_blink_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CSR_W-1:0] csr_addr,
    input  logic [CSR_W-1:0] csr_wdata,
    input  logic             csr_write,
    output logic [CSR_W-1:0] csr_rdata,
    output logic [N_CH-1:0]  led_out
);

`ifdef LED_MULTI_BLINK_PWM_EN
    localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_FULL;
`else
    localparam logic [DUTY_W-1:0] DUTY_RST = '0;
`endif
    localparam ctrl_t CTRL_RST = '{duty: DUTY_RST, oneshot: 1'b0, rate: '0, enable: 1'b0};

    ctrl_t            ctrl_q [N_CH];
    ctrl_t            ctrl_d [N_CH];
    ctrl_t            wr_ctrl;
    logic [N_CH-1:0]  done_q, done_d;
    logic [N_CH-1:0]  chan_on, chan_done, restart;
    logic [IDX_W-1:0] ctrl_idx;
    logic             ctrl_hit, status_hit, done_hit;
    logic             unused_wdata;

    assign ctrl_idx   = csr_addr[IDX_W+1:2];
    assign ctrl_hit   = (csr_addr[CSR_W-1:IDX_W+2] == '0) && (csr_addr[1:0] == 2'b00)
                        && (32'(ctrl_idx) < N_CH);
    assign status_hit = (csr_addr == STATUS_ADDR);
    assign done_hit   = (csr_addr == DONE_ADDR);
    assign unused_wdata = ^csr_wdata[CSR_W-1:6];

    // CSR writes win over one-shot auto-clear; DONE set wins over a same-cycle W1C.
    always_comb begin
        wr_ctrl = ctrl_unpack(csr_wdata);
`ifdef LED_MULTI_BLINK_PWM_EN
`else
        wr_ctrl.duty = '0;
`endif
        done_d = done_q;
        if (csr_write && done_hit) begin
            done_d = done_d & ~csr_wdata[N_CH-1:0];
        end
        done_d = done_d | chan_done;
        for (int ch = 0; ch < N_CH; ch++) begin
            ctrl_d[ch] = ctrl_q[ch];
            if (chan_done[ch]) begin
                ctrl_d[ch].enable  = 1'b0;
                ctrl_d[ch].oneshot = 1'b0;
            end
            if (csr_write && ctrl_hit && (ctrl_idx == IDX_W'(ch))) begin
                ctrl_d[ch] = wr_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                ctrl_q[ch] <= CTRL_RST;
            end
            done_q <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                ctrl_q[ch] <= ctrl_d[ch];
            end
            done_q <= done_d;
        end
    end

    // Zero-latency read port.
    always_comb begin
        csr_rdata = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (ctrl_hit && (ctrl_idx == IDX_W'(ch))) begin
                csr_rdata = ctrl_pack(ctrl_q[ch]);
            end
        end
        if (status_hit) begin
            csr_rdata = CSR_W'(led_out);
        end else if (done_hit) begin
            csr_rdata = CSR_W'(done_q);
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
        // A CTRL write that keeps ENABLE set restarts the count without changing phase.
        assign restart[ch] = csr_write && ctrl_hit && (ctrl_idx == IDX_W'(ch))
                             && ctrl_q[ch].enable && csr_wdata[CTRL_ENABLE_BIT];

        led_blink_chan #(
            .PRESCALE (PRESCALE)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .enable_i  (ctrl_q[ch].enable),
            .oneshot_i (ctrl_q[ch].oneshot),
            .rate_i    (ctrl_q[ch].rate),
            .restart_i (restart[ch]),
            .on_o      (chan_on[ch]),
            .done_c    (chan_done[ch])
        );
    end

`ifdef LED_MULTI_BLINK_PWM_EN
    logic [DUTY_W-1:0] pwm_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
        end
    end

    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            led_out[ch] = chan_on[ch] &&
                          ((ctrl_q[ch].duty == DUTY_FULL) || (pwm_cnt_q < ctrl_q[ch].duty));
        end
    end
`else
    assign led_out = chan_on;
`endif

endmodule

// File: tb/tb_led_multi_blink.sv
// Scoreboard bench for led_multi_blink: stimulus queues expected LED vectors and CSR reads
// stamped with a cycle number; a negedge monitor retires them. LED_MULTI_BLINK_PWM_EN adds PWM checks.
module tb_led_multi_blink;

    localparam int unsigned N_CH     = 4;
    localparam int unsigned PRESCALE = 4;
`ifdef LED_MULTI_BLINK_PWM_EN
    localparam logic [31:0] DUTY_BITS = 32'h0000_FF00;
`else
    localparam logic [31:0] DUTY_BITS = 32'h0000_0000;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     csr_addr;
    logic [31:0]     csr_wdata;
    logic            csr_write;
    logic [31:0]     csr_rdata;
    logic [N_CH-1:0] led_out;

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    int          q_at   [$];
    bit          q_rd   [$];
    logic [31:0] q_exp  [$];
    string       q_name [$];

    led_multi_blink #(
        .N_CH     (N_CH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_write (csr_write),
        .csr_rdata (csr_rdata),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef LED_MULTI_BLINK_PWM_EN
    logic [7:0] pwm_ref;
    always @(posedge clk or posedge rst) begin
        if (rst) pwm_ref <= 8'd0;
        else     pwm_ref <= pwm_ref + 8'd1;
    end
`endif

    // Monitor: retire every scoreboard entry stamped with the current cycle.
    always @(negedge clk) begin
        int i;
        logic [31:0] act;
        i = 0;
        while (i < q_at.size()) begin
            if (q_at[i] <= cyc) begin
                act = q_rd[i] ? csr_rdata : 32'(led_out);
                n_vec++;
                if (q_at[i] < cyc) begin
                    n_bad++;
                    $display("FAIL %s: entry for cycle %0d missed (now %0d)", q_name[i], q_at[i], cyc);
                end else if (act !== q_exp[i]) begin
                    n_bad++;
                    $display("FAIL %s @cycle %0d: got %h, expected %h", q_name[i], cyc, act, q_exp[i]);
                end
                q_at.delete(i);
                q_rd.delete(i);
                q_exp.delete(i);
                q_name.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_led(input int at, input logic [N_CH-1:0] v, input string nm);
        q_at.push_back(at);
        q_rd.push_back(1'b0);
        q_exp.push_back(32'(v));
        q_name.push_back(nm);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
        csr_addr = a;
        q_at.push_back(cyc);
        q_rd.push_back(1'b1);
        q_exp.push_back(v);
        q_name.push_back(nm);
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_write = 1'b1;
        tick();
        csr_write = 1'b0;
        csr_wdata = 32'h0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        int w, r, d, s, x;
        csr_addr  = 32'h0;
        csr_wdata = 32'h0;
        csr_write = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        expect_led(cyc, 4'h0, "rst_led");
        rd(32'h00, DUTY_BITS, "rst_ctrl0");
        rd(32'h0C, DUTY_BITS, "rst_ctrl3");
        rd(32'h44, 32'h0, "rst_done");

        // Ch0 blink, RATE=2 -> half period 12.
        w = cyc;
        expect_led(w + 1,  4'h0, "blink_pre");
        expect_led(w + 2,  4'h1, "blink_rise");
        expect_led(w + 13, 4'h1, "blink_on_end");
        expect_led(w + 14, 4'h0, "blink_fall");
        expect_led(w + 25, 4'h0, "blink_off_end");
        expect_led(w + 26, 4'h1, "blink_rise2");
        wr(32'h00, DUTY_BITS | 32'h5);
        rd(32'h00, DUTY_BITS | 32'h5, "blink_ctrl0");
        wait_until(w + 30);

        // Mid-ON rewrite with RATE=1: counter restarts, phase kept, half period 8.
        r = cyc;
        expect_led(r + 8,  4'h1, "restart_hold");
        expect_led(r + 9,  4'h0, "restart_fall");
        expect_led(r + 16, 4'h0, "restart_off_end");
        expect_led(r + 17, 4'h1, "restart_rise");
        wr(32'h00, DUTY_BITS | 32'h3);
        wait_until(r + 18);

        d = cyc;
        expect_led(d + 2, 4'h0, "disable_off");
        expect_led(d + 6, 4'h0, "disable_idle");
        wr(32'h00, DUTY_BITS);
        wait_until(d + 8);

        // Ch1 one-shot, RATE=0 -> high exactly 4 cycles.
        w = cyc;
        expect_led(w + 1, 4'h0, "os_pre");
        expect_led(w + 2, 4'h2, "os_rise");
        expect_led(w + 5, 4'h2, "os_last");
        expect_led(w + 6, 4'h0, "os_fall");
        expect_led(w + 9, 4'h0, "os_stay");
        wr(32'h04, DUTY_BITS | 32'h21);
        wait_until(w + 5);
        rd(32'h44, 32'h0, "os_done_early");
        rd(32'h04, DUTY_BITS, "os_ctrl_clr");
        rd(32'h44, 32'h2, "os_done_set");
        wr(32'h44, 32'h0);
        rd(32'h44, 32'h2, "done_w0_noop");
        wr(32'h44, 32'h2);
        rd(32'h44, 32'h0, "done_w1c");

        // DONE set and W1C of the same bit in one cycle: set wins.
        w = cyc;
        wr(32'h00, DUTY_BITS | 32'h21);
        wait_until(w + 5);
        wr(32'h44, 32'h1);
        rd(32'h44, 32'h1, "done_set_wins");
        wr(32'h44, 32'h1);
        rd(32'h44, 32'h0, "done_clr_again");

        // Four channels, RATE 0..3, started on consecutive cycles.
        s = cyc;
        expect_led(s + 5,  4'hF, "multi_s5");
        expect_led(s + 6,  4'hE, "multi_s6");
        expect_led(s + 10, 4'hF, "multi_s10");
        expect_led(s + 11, 4'hD, "multi_s11");
        expect_led(s + 16, 4'h8, "multi_s16");
        expect_led(s + 21, 4'h3, "multi_s21");
        wr(32'h00, DUTY_BITS | 32'h1);
        wr(32'h04, DUTY_BITS | 32'h3);
        wr(32'h08, DUTY_BITS | 32'h5);
        wr(32'h0C, DUTY_BITS | 32'h7);
        wait_until(s + 16);
        rd(32'h40, 32'h8, "status");
        rd(32'h48, 32'h0, "unmapped_rd");
        wr(32'h01, 32'h0);
        rd(32'h02, 32'h0, "unaligned_rd");
        wait_until(s + 24);

        // Asynchronous reset mid-blink.
        x = cyc;
        #1 rst = 1'b1;
        expect_led(x, 4'h0, "rst_async");
        tick();
        tick();
        rst = 1'b0;
        expect_led(cyc + 4, 4'h0, "rst_no_resume");
        rd(32'h44, 32'h0, "rst_no_done");
        rd(32'h00, DUTY_BITS, "rst_ctrl0_clr");
        wait_until(cyc + 6);
        w = cyc;
        expect_led(w + 2, 4'h4, "resume_rise");
        expect_led(w + 6, 4'h0, "resume_fall");
        wr(32'h08, DUTY_BITS | 32'h1);
        wait_until(w + 8);
        wr(32'h08, DUTY_BITS);
        repeat (4) tick();

`ifdef LED_MULTI_BLINK_PWM_EN
        begin
            logic [7:0] p;
            int q;
            // DUTY=0x40 held ON for 256 cycles by periodic restarts.
            w = cyc;
            p = pwm_ref;
            for (int k = 2; k < 258; k++) begin
                expect_led(w + k, (8'(p + 8'(k)) < 8'h40) ? 4'h1 : 4'h0, "pwm_duty40");
            end
            wr(32'h00, 32'h0000_401F);
            while (cyc < w + 258) begin
                if ((cyc - w) % 50 == 49) wr(32'h00, 32'h0000_401F);
                else tick();
            end
            q = cyc;
            for (int k = 2; k < 10; k++) expect_led(q + k, 4'h0, "pwm_duty0");
            wr(32'h00, 32'h0000_001F);
            wait_until(q + 10);
            q = cyc;
            for (int k = 2; k < 9; k++) expect_led(q + k, 4'h1, "pwm_duty_ff");
            wr(32'h00, 32'h0000_FF1F);
            wait_until(q + 10);
            wr(32'h00, DUTY_BITS);
            repeat (4) tick();
        end
`endif

        repeat (3) tick();
        if (q_at.size() != 0) begin
            n_bad += q_at.size();
            $display("FAIL scoreboard: %0d entries never retired", q_at.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
